fp_add_align_stage: RTL and testbench
=====================================

FP_ADD_ALIGN_STAGE -- requirements
Module: fp_add_align_stage

Interface
REQ-001 Parameters: none; widths fixed to IEEE-754 binary32 and the downstream normaliser's 8-bit exponent / 25-bit mantissa format.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  stage accepts operand pair this cycle.
REQ-006 in_a  input  32  binary32 operand A.
REQ-007 in_b  input  32  binary32 operand B.
REQ-008 in_sub  input  1  1 = compute A-B, 0 = A+B.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream normaliser accepts result.
REQ-011 out_s  output  1  result sign.
REQ-012 out_e  output  8  biased exponent of result, pre-normalisation.
REQ-013 out_m  output  25  mantissa; bit23 = hidden-bit position, bit24 always 0 at output.
REQ-014 out_zero  output  1  exact-zero result; out_e=0, out_m=0.
REQ-015 out_special  output  1  either operand has exponent 255; out_e=255, out_m=0, out_s=sign of that operand (A priority).

Function
REQ-016 Two-stage pipeline; a pair accepted in cycle N appears on out_* in cycle N+2 when not stalled.
REQ-017 Transfer on a port occurs only when valid and ready are both high in the same cycle.
REQ-018 Stage 1 (align): effective sign of B = in_b[31] XOR in_sub; operand with larger {exp,frac} magnitude becomes "big"; smaller mantissa shifted right by exponent difference.
REQ-019 Exponent 0 operands are flushed to zero (hidden bit 0, fraction ignored); no denormal support.
REQ-020 Exponent difference >= 24: aligned small mantissa = 0.
REQ-021 Bits shifted out during alignment are truncated; no guard/round/sticky bits.
REQ-022 Stage 2 (add): equal effective signs -> add 24-bit mantissas; differing -> big minus small; out_s = sign of big.
REQ-023 Carry out of add (sum bit24 = 1): mantissa shifted right 1 (LSB truncated), exponent +1.
REQ-024 Carry with big exponent 254 -> out_special=1, out_e=255, out_m=0.
REQ-025 Subtraction result 0 -> out_zero=1, out_s=0, out_e=0, out_m=0.
REQ-026 Non-carry, non-zero results leave leading one at bit23 or below with out_e = big exponent; leading-one shifting is the downstream normaliser's job.
REQ-027 Each stage holds a valid bit; stage advances when the following stage is empty or transferring this cycle.
REQ-028 in_ready = NOT stage1_valid OR stage1 advancing; combinational path from out_ready to in_ready permitted.
REQ-029 out_* hold stable while out_valid=1 and out_ready=0.
REQ-030 Simultaneous accept and emit in one cycle sustains full throughput: one result per cycle.

Reset
REQ-031 rst_n low clears both stage valid bits immediately; out_valid=0, out_s=0, out_e=0, out_m=0, out_zero=0, out_special=0.
REQ-032 In-flight pairs at reset are discarded; no output after release until a new pair is accepted.
REQ-033 in_ready=1 in the first cycle after reset release.

Structure
REQ-034 Shared package holds binary32 field widths, bias 127, exponent-max 255, and the aligned-operand struct (sign, exp, 25-bit mantissa, flags).
REQ-035 One sub-module natural: fp_mant_align (combinational compare/swap plus right barrel shift), instantiated in stage 1.

Verification
REQ-036 0x3F800000 + 0x3F800000, in_sub=0 -> after 2 cycles out_s=0, out_e=128, out_m=0x0800000.
REQ-037 0x3FC00000 - 0x3F800000 (in_sub=1) -> out_s=0, out_e=127, out_m=0x0400000, out_zero=0.
REQ-038 0x40490FDB - 0x40490FDB -> out_zero=1, out_s=0, out_e=0, out_m=0; 0x3F800000 + 0x30800000 (diff 30) -> out_e=127, out_m=0x0800000.
REQ-039 0x7F000000 + 0x7F000000 -> out_special=1, out_e=255; 0x7F800000 + any -> out_special=1.
REQ-040 Back-to-back 4 pairs, out_ready low 3 cycles -> in_ready falls after 2 accepted, outputs held stable, all 4 results emerge in order with none lost or duplicated.
REQ-041 rst_n pulsed low with 2 pairs in flight -> out_valid=0 at once, no stale results after release, in_ready=1 first cycle.

Source files
------------

// File: rtl/fp_add_align_stage_pkg.sv
// Shared binary32 field widths and the aligned-operand record passed from
// the align stage to the add stage of the FP adder front end.
package fp_add_align_stage_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 25;
  localparam int unsigned BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX         = 8'd255;
  localparam logic [EXP_W-1:0] EXP_CARRY_LIMIT = 8'd254;

  typedef struct packed {
    logic              sign;        // sign of big operand, or of the special operand
    logic [EXP_W-1:0]  exp;         // exponent of big operand
    logic [MANT_W-1:0] mant_big;
    logic [MANT_W-1:0] mant_small;  // already shifted to big's exponent
    logic              eff_sub;     // effective signs differ
    logic              special;     // an operand had exponent 255
  } aligned_op_t;

endpackage

// File: rtl/fp_mant_align.sv
// Combinational compare/swap and right alignment of the smaller mantissa.
module fp_mant_align
  import fp_add_align_stage_pkg::*;
(
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  input  logic              sub,
  output aligned_op_t       aligned
);

  logic [EXP_W-1:0]  e_a, e_b, e_big, e_small, diff;
  logic [FRAC_W-1:0] f_a, f_b;
  logic [MANT_W-1:0] m_a, m_b, m_small;
  logic              s_a, s_b, a_big;

  always_comb begin
    e_a = op_a[30:23];
    e_b = op_b[30:23];
    // Exponent-0 operands flush to zero, so their fraction is dropped entirely.
    f_a = (e_a == '0) ? '0 : op_a[22:0];
    f_b = (e_b == '0) ? '0 : op_b[22:0];
    m_a = {1'b0, |e_a, f_a};
    m_b = {1'b0, |e_b, f_b};
    s_a = op_a[31];
    s_b = op_b[31] ^ sub;

    a_big   = {e_a, f_a} >= {e_b, f_b};
    e_big   = a_big ? e_a : e_b;
    e_small = a_big ? e_b : e_a;
    m_small = a_big ? m_b : m_a;
    diff    = e_big - e_small;

    aligned            = '0;
    aligned.exp        = e_big;
    aligned.mant_big   = a_big ? m_a : m_b;
    aligned.mant_small = (diff >= 8'd24) ? '0 : (m_small >> diff);
    aligned.eff_sub    = s_a ^ s_b;
    aligned.sign       = a_big ? s_a : s_b;
    aligned.special    = (e_a == EXP_MAX) || (e_b == EXP_MAX);
    if (e_a == EXP_MAX)
      aligned.sign = op_a[31];
    else if (e_b == EXP_MAX)
      aligned.sign = op_b[31];
  end

endmodule

// File: rtl/fp_add_align_stage.sv
// Two-stage binary32 add/sub front end: align, then mantissa add with
// single-step carry correction; leading-one normalisation happens downstream.
module fp_add_align_stage
  import fp_add_align_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_s,
  output logic [EXP_W-1:0]  out_e,
  output logic [MANT_W-1:0] out_m,
  output logic              out_zero,
  output logic              out_special
);

  aligned_op_t       align_d, s1_q;
  logic              s1_valid, s2_advance;
  logic [MANT_W-1:0] sum;
  logic              nx_s, nx_zero, nx_special;
  logic [EXP_W-1:0]  nx_e;
  logic [MANT_W-1:0] nx_m;

  fp_mant_align u_align (
    .op_a    (in_a),
    .op_b    (in_b),
    .sub     (in_sub),
    .aligned (align_d)
  );

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_comb begin
    sum = s1_q.eff_sub ? (s1_q.mant_big - s1_q.mant_small)
                       : (s1_q.mant_big + s1_q.mant_small);
    nx_s       = s1_q.sign;
    nx_e       = s1_q.exp;
    nx_m       = sum;
    nx_zero    = 1'b0;
    nx_special = 1'b0;
    if (s1_q.special) begin
      nx_e       = EXP_MAX;
      nx_m       = '0;
      nx_special = 1'b1;
    end else if (sum == '0) begin
      nx_s    = 1'b0;
      nx_e    = '0;
      nx_zero = 1'b1;
    end else if (sum[MANT_W-1]) begin
      if (s1_q.exp == EXP_CARRY_LIMIT) begin
        nx_e       = EXP_MAX;
        nx_m       = '0;
        nx_special = 1'b1;
      end else begin
        nx_m = {1'b0, sum[MANT_W-1:1]};
        nx_e = s1_q.exp + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid)
        s1_q <= align_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_s       <= 1'b0;
      out_e       <= '0;
      out_m       <= '0;
      out_zero    <= 1'b0;
      out_special <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_s       <= nx_s;
        out_e       <= nx_e;
        out_m       <= nx_m;
        out_zero    <= nx_zero;
        out_special <= nx_special;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_align_stage.sv
// Bench for fp_add_align_stage: directed vectors, stall/back-pressure,
// reset with pairs in flight, and randomized traffic against a value model.
module tb_fp_add_align_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_s;
  logic [7:0]  out_e;
  logic [24:0] out_m;
  logic        out_zero;
  logic        out_special;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];

  always #5 clk = ~clk;

  fp_add_align_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_sub      (in_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_s       (out_s),
    .out_e       (out_e),
    .out_m       (out_m),
    .out_zero    (out_zero),
    .out_special (out_special)
  );

  // Result as {sign, exponent, mantissa, zero, special}, from real-number rules.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint ea, eb, ma, mb, e_big, e_sm, m_big, m_sm, d, r;
    logic   sa, sb, s_big, s_sm;
    ea = longint'(a[30:23]);
    eb = longint'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ sub;
    if (ea == 255) return {a[31], 8'hFF, 25'd0, 2'b01};
    if (eb == 255) return {b[31], 8'hFF, 25'd0, 2'b01};
    ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
    mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
    if (ea * (longint'(1) << 24) + ma >= eb * (longint'(1) << 24) + mb) begin
      e_big = ea; m_big = ma; s_big = sa; e_sm = eb; m_sm = mb; s_sm = sb;
    end else begin
      e_big = eb; m_big = mb; s_big = sb; e_sm = ea; m_sm = ma; s_sm = sa;
    end
    d = e_big - e_sm;
    m_sm = (d >= 24) ? 0 : m_sm / (longint'(1) << d);
    r = (s_big == s_sm) ? m_big + m_sm : m_big - m_sm;
    if (r == 0) return {1'b0, 8'd0, 25'd0, 2'b10};
    if (r >= (longint'(1) << 24)) begin
      if (e_big == 254) return {s_big, 8'hFF, 25'd0, 2'b01};
      r = r / 2;
      e_big = e_big + 1;
    end
    return {s_big, 8'(e_big), 25'(r), 2'b00};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int unsigned sel;
    sel = $urandom_range(0, 99);
    if (sel < 8)       e = 8'd0;
    else if (sel < 12) e = 8'd255;
    else if (sel < 18) e = 8'd254;
    else               e = 8'($urandom_range(1, 253));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_partner(input logic [31:0] a);
    int unsigned sel;
    int          e;
    sel = $urandom_range(0, 99);
    if (sel < 20) return {1'($urandom), a[30:0]};
    if (sel < 60) begin
      e = int'(a[30:23]) + $urandom_range(0, 60) - 30;
      if (e < 0) e = 0;
      if (e > 254) e = 254;
      return {1'($urandom), 8'(e), 23'($urandom)};
    end
    return rand_fp();
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub));
    if (rst_n && out_valid && out_ready) got_q.push_back({out_s, out_e, out_m, out_zero, out_special});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({out_valid, out_s, out_e, out_m, out_zero, out_special} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b s=%b e=%h m=%h z=%b sp=%b required all 0",
               out_valid, out_s, out_e, out_m, out_zero, out_special);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    step();
  endtask

  task automatic test_directed();
    logic [31:0] va[12];
    logic [31:0] vb[12];
    logic        vs[12];
    logic [35:0] ve[12];
    va = '{32'h3F800000, 32'h3FC00000, 32'h40490FDB, 32'h3F800000, 32'h7F000000, 32'h7F800000,
           32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hC0000000};
    vb = '{32'h3F800000, 32'h3F800000, 32'h40490FDB, 32'h30800000, 32'h7F000000, 32'h3F800000,
           32'h7F800000, 32'h40000000, 32'h34000000, 32'h33800000, 32'h00400000, 32'h3F800000};
    vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ve = '{{1'b0, 8'd128, 25'h0800000, 2'b00}, {1'b0, 8'd127, 25'h0400000, 2'b00},
           {1'b0, 8'd0,   25'h0000000, 2'b10}, {1'b0, 8'd127, 25'h0800000, 2'b00},
           {1'b0, 8'd255, 25'h0000000, 2'b01}, {1'b0, 8'd255, 25'h0000000, 2'b01},
           {1'b1, 8'd255, 25'h0000000, 2'b01}, {1'b1, 8'd128, 25'h0400000, 2'b00},
           {1'b0, 8'd127, 25'h0800001, 2'b00}, {1'b0, 8'd127, 25'h0800000, 2'b00},
           {1'b0, 8'd127, 25'h0800000, 2'b00}, {1'b1, 8'd128, 25'h0400000, 2'b00}};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_a = va[i]; in_b = vb[i]; in_sub = vs[i]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if ({out_valid, out_s, out_e, out_m, out_zero, out_special} !== {1'b1, ve[i]}) begin
        errors++;
        $display("FAIL directed_%0d got valid=%b s=%b e=%0d m=%h z=%b sp=%b required valid=1 %h",
                 i, out_valid, out_s, out_e, out_m, out_zero, out_special, ve[i]);
      end
      step();
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    logic        ps[4];
    logic [36:0] snap;
    int          accepted, cyc, last_out;
    logic        acc_now;
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_fp(); pb[i] = rand_partner(pa[i]); ps[i] = 1'($urandom);
    end
    exp_q.delete();
    got_q.delete();
    accepted = 0; cyc = 0; last_out = -1; snap = '0;
    out_ready = 1'b0;
    in_a = pa[0]; in_b = pb[0]; in_sub = ps[0]; in_valid = 1'b1;
    while ((accepted < 4 || got_q.size() < 4) && cyc < 60) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (out_valid && out_ready) last_out = cyc;
      if (cyc == 2) begin
        checks++;
        if (accepted !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall_ready got accepted=%0d in_ready=%b out_valid=%b required 2 0 1",
                   accepted, in_ready, out_valid);
        end
        snap = {out_valid, out_s, out_e, out_m, out_zero, out_special};
      end
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if ({out_valid, out_s, out_e, out_m, out_zero, out_special} !== snap) begin
          errors++;
          $display("FAIL b2b_hold_c%0d got %h required %h", cyc,
                   {out_valid, out_s, out_e, out_m, out_zero, out_special}, snap);
        end
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        accepted++;
        if (accepted < 4) begin
          in_a = pa[accepted]; in_b = pb[accepted]; in_sub = ps[accepted];
        end else begin
          in_valid = 1'b0;
        end
      end
      cyc++;
      out_ready = (cyc >= 5);
    end
    checks++;
    if (last_out != 8) begin
      errors++;
      $display("FAIL b2b_throughput last result cycle %0d required 8", last_out);
    end
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d results for %0d accepted required 4", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [35:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_result got %h required %h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_in_flight();
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_a = rand_fp(); in_b = rand_partner(in_a); in_sub = 1'($urandom); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_s, out_e, out_m, out_zero, out_special} !== 37'd0) begin
      errors++;
      $display("FAIL rst_flight_async got valid=%b e=%h m=%h required all 0", out_valid, out_e, out_m);
    end
    exp_q.delete();
    got_q.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_flight_in_ready got %b required 1", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_flight_stale cycle %0d got out_valid=%b required 0", i, out_valid);
      end
      @(negedge clk);
    end
    step();
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL rst_flight_no_output got %0d results required 0", got_q.size());
    end
  endtask

  task automatic test_random();
    int          sent, n;
    logic        acc_now, stalled;
    logic [36:0] snap;
    exp_q.delete();
    got_q.delete();
    sent = 0; stalled = 1'b0; snap = '0;
    in_a = rand_fp(); in_b = rand_partner(in_a); in_sub = 1'($urandom);
    in_valid = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 9) < 7);
    n = 0;
    while (sent < 300 && n < 5000) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (stalled) begin
        checks++;
        if ({out_valid, out_s, out_e, out_m, out_zero, out_special} !== snap) begin
          errors++;
          $display("FAIL rand_hold got %h required %h",
                   {out_valid, out_s, out_e, out_m, out_zero, out_special}, snap);
        end
      end
      stalled = out_valid && !out_ready;
      snap = {out_valid, out_s, out_e, out_m, out_zero, out_special};
      @(posedge clk);
      #1;
      if (acc_now) begin
        sent++;
        in_a = rand_fp(); in_b = rand_partner(in_a); in_sub = 1'($urandom);
      end
      if (acc_now || !in_valid) in_valid = ($urandom_range(0, 3) != 0) && (sent < 300);
      out_ready = ($urandom_range(0, 9) < 7);
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (sent != 300 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_drain sent %0d got %0d results for %0d accepted required 300 equal",
               sent, got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [35:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rand_result got %h required %h", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
